// File: rtl/cci_mpf_shim_rsp_buffer_lockstep.sv
// Lockstep c0/c1 response FIFO with credit accounting toward the QLP.
// Requests reserve a slot at issue; txAlmFull throttles issue when free credits run low.
module cci_mpf_shim_rsp_buffer_lockstep #(
  parameter int unsigned N_ENTRIES = 32,
  parameter int unsigned THRESHOLD = 4,
  parameter int unsigned C0RX_BITS = 600,
  parameter int unsigned C1RX_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_c0_valid,
  input  logic [C0RX_BITS-1:0] rx_c0_data,
  input  logic                 rx_c1_valid,
  input  logic [C1RX_BITS-1:0] rx_c1_data,
  input  logic                 req_c0_issue,
  input  logic                 req_c1_issue,
  output logic                 txAlmFull,
  output logic                 first_c0_valid,
  output logic [C0RX_BITS-1:0] first_c0,
  output logic                 first_c1_valid,
  output logic [C1RX_BITS-1:0] first_c1,
  output logic                 notEmpty,
  input  logic                 deqRx,
  output logic                 err_overflow,
  output logic                 err_orphan
);

  localparam int unsigned CW = $clog2(N_ENTRIES + 1) + 1;
  localparam int unsigned PW = $clog2(N_ENTRIES);
  localparam int unsigned FW = CW + 3;
  localparam logic signed [FW-1:0] THRESH_S = FW'(THRESHOLD);

  logic [CW-1:0] occ_q, occ_d, out_c0_q, out_c0_d, out_c1_q, out_c1_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          err_overflow_q, err_overflow_d, err_orphan_q, err_orphan_d;
  logic          enq_c, deq_c, full_c, wr_en_c;
  logic signed [FW-1:0] free_c;

  logic [C0RX_BITS-1:0] mem_c0 [N_ENTRIES];
  logic [C1RX_BITS-1:0] mem_c1 [N_ENTRIES];
  logic                 mem_v0 [N_ENTRIES];
  logic                 mem_v1 [N_ENTRIES];

  // Next-state for counters, pointers and sticky error flags.
  always_comb begin
    enq_c   = rx_c0_valid | rx_c1_valid;
    deq_c   = deqRx & (occ_q != '0);
    full_c  = (occ_q == CW'(N_ENTRIES));
    wr_en_c = enq_c & (~full_c | deq_c);

    occ_d    = occ_q + CW'(wr_en_c) - CW'(deq_c);
    wr_ptr_d = wr_ptr_q + PW'(wr_en_c);
    rd_ptr_d = rd_ptr_q + PW'(deq_c);

    out_c0_d = out_c0_q + CW'(req_c0_issue) - CW'(rx_c0_valid);
    out_c1_d = out_c1_q + CW'(req_c1_issue) - CW'(rx_c1_valid);
    // An orphan response never drives the outstanding count below zero.
    if (rx_c0_valid && (out_c0_q == '0)) out_c0_d = '0;
    if (rx_c1_valid && (out_c1_q == '0)) out_c1_d = '0;

    err_orphan_d   = err_orphan_q
                   | (rx_c0_valid & (out_c0_q == '0))
                   | (rx_c1_valid & (out_c1_q == '0));
    err_overflow_d = err_overflow_q | (enq_c & full_c & ~deq_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q          <= '0;
      out_c0_q       <= '0;
      out_c1_q       <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      err_overflow_q <= 1'b0;
      err_orphan_q   <= 1'b0;
    end else begin
      occ_q          <= occ_d;
      out_c0_q       <= out_c0_d;
      out_c1_q       <= out_c1_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      err_overflow_q <= err_overflow_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  // Unreset storage; stale contents are masked by notEmpty.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_c0[wr_ptr_q] <= rx_c0_data;
      mem_c1[wr_ptr_q] <= rx_c1_data;
      mem_v0[wr_ptr_q] <= rx_c0_valid;
      mem_v1[wr_ptr_q] <= rx_c1_valid;
    end
  end

  always_comb begin
    free_c = FW'(N_ENTRIES) - FW'(occ_q) - FW'(out_c0_q) - FW'(out_c1_q);
  end

  assign txAlmFull      = (free_c <= THRESH_S);
  assign notEmpty       = (occ_q != '0);
  assign first_c0_valid = notEmpty & mem_v0[rd_ptr_q];
  assign first_c1_valid = notEmpty & mem_v1[rd_ptr_q];
  assign first_c0       = mem_c0[rd_ptr_q];
  assign first_c1       = mem_c1[rd_ptr_q];
  assign err_overflow   = err_overflow_q;
  assign err_orphan     = err_orphan_q;

endmodule

// File: tb/tb_cci_mpf_shim_rsp_buffer_lockstep.sv
// Bench for the lockstep response buffer: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_cci_mpf_shim_rsp_buffer_lockstep;
  localparam int N  = 8;
  localparam int TH = 4;
  localparam int W0 = 64;
  localparam int W1 = 16;

  typedef struct packed {
    logic          v0;
    logic          v1;
    logic [W0-1:0] d0;
    logic [W1-1:0] d1;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_c0_valid, rx_c1_valid, req_c0_issue, req_c1_issue, deqRx;
  logic [W0-1:0] rx_c0_data, first_c0;
  logic [W1-1:0] rx_c1_data, first_c1;
  logic          txAlmFull, first_c0_valid, first_c1_valid, notEmpty;
  logic          err_overflow, err_orphan;

  int checks = 0;
  int errors = 0;

  ent_t mq[$];
  int   m_out0, m_out1;
  bit   m_ovf, m_orph;

  cci_mpf_shim_rsp_buffer_lockstep #(
    .N_ENTRIES(N), .THRESHOLD(TH), .C0RX_BITS(W0), .C1RX_BITS(W1)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_c0_valid(rx_c0_valid), .rx_c0_data(rx_c0_data),
    .rx_c1_valid(rx_c1_valid), .rx_c1_data(rx_c1_data),
    .req_c0_issue(req_c0_issue), .req_c1_issue(req_c1_issue),
    .txAlmFull(txAlmFull),
    .first_c0_valid(first_c0_valid), .first_c0(first_c0),
    .first_c1_valid(first_c1_valid), .first_c1(first_c1),
    .notEmpty(notEmpty), .deqRx(deqRx),
    .err_overflow(err_overflow), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  function automatic bit exp_alm();
    return (N - mq.size() - m_out0 - m_out1) <= TH;
  endfunction

  task automatic idle();
    rx_c0_valid = 0; rx_c1_valid = 0; req_c0_issue = 0; req_c1_issue = 0; deqRx = 0;
    rx_c0_data = {$urandom, $urandom}; rx_c1_data = W1'($urandom);
  endtask

  // Clock edge with the reference model applying the spec rules to the sampled inputs.
  task automatic cycle();
    ent_t e;
    bit   full, do_deq, enq;
    int   n0, n1;
    @(posedge clk);
    if (reset) begin
      mq.delete(); m_out0 = 0; m_out1 = 0; m_ovf = 0; m_orph = 0;
    end else begin
      enq    = rx_c0_valid || rx_c1_valid;
      full   = (mq.size() == N);
      do_deq = deqRx && (mq.size() > 0);
      e = '{v0: rx_c0_valid, v1: rx_c1_valid, d0: rx_c0_data, d1: rx_c1_data};
      if (enq && full && !do_deq) m_ovf = 1;
      if ((rx_c0_valid && m_out0 == 0) || (rx_c1_valid && m_out1 == 0)) m_orph = 1;
      if (do_deq) void'(mq.pop_front());
      if (enq && !(full && !do_deq)) mq.push_back(e);
      n0 = m_out0 + int'(req_c0_issue) - int'(rx_c0_valid);
      n1 = m_out1 + int'(req_c1_issue) - int'(rx_c1_valid);
      m_out0 = (n0 < 0) ? 0 : n0;
      m_out1 = (n1 < 0) ? 0 : n1;
    end
    #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1; cycle(); cycle(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    cycle(); cycle();
    checks++; if (notEmpty !== 1'b0) begin errors++; $display("FAIL reset_notEmpty got=%b exp=0", notEmpty); end
    checks++; if (txAlmFull !== 1'b0) begin errors++; $display("FAIL reset_txAlmFull got=%b exp=0", txAlmFull); end
    checks++; if ({first_c0_valid, first_c1_valid} !== 2'b00) begin errors++; $display("FAIL reset_first_valid got=%b%b exp=00", first_c0_valid, first_c1_valid); end
    checks++; if ({err_overflow, err_orphan} !== 2'b00) begin errors++; $display("FAIL reset_errors got=%b%b exp=00", err_overflow, err_orphan); end
  endtask

  task automatic test_credit_throttle();
    ent_t h;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_c0_issue = 1; cycle();
      checks++; if (txAlmFull !== (i == 3) || txAlmFull !== exp_alm()) begin errors++; $display("FAIL issue_alm[%0d] got=%b exp=%b", i, txAlmFull, (i == 3)); end
    end
    req_c0_issue = 0;
    for (int i = 0; i < 4; i++) begin
      rx_c0_valid = 1; rx_c0_data = {$urandom, $urandom}; cycle();
      checks++; if (txAlmFull !== 1'b1) begin errors++; $display("FAIL rsp_alm[%0d] got=%b exp=1", i, txAlmFull); end
    end
    idle();
    h = mq[0];
    checks++; if (notEmpty !== 1'b1 || first_c0 !== h.d0 || first_c0_valid !== 1'b1 || first_c1_valid !== 1'b0) begin errors++; $display("FAIL throttle_head got=%b/%h exp=1/%h", notEmpty, first_c0, h.d0); end
    deqRx = 1; cycle(); deqRx = 0;
    checks++; if (txAlmFull !== 1'b0) begin errors++; $display("FAIL deq_alm got=%b exp=0", txAlmFull); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL throttle_orphan got=%b exp=0", err_orphan); end
  endtask

  task automatic test_shared_entry();
    logic [W0-1:0] d0;
    logic [W1-1:0] d1;
    do_reset();
    req_c0_issue = 1; req_c1_issue = 1; cycle(); idle();
    d0 = {$urandom, $urandom}; d1 = W1'($urandom);
    rx_c0_valid = 1; rx_c1_valid = 1; rx_c0_data = d0; rx_c1_data = d1; cycle(); idle();
    checks++; if ({first_c0_valid, first_c1_valid} !== 2'b11) begin errors++; $display("FAIL shared_valid got=%b%b exp=11", first_c0_valid, first_c1_valid); end
    checks++; if (first_c0 !== d0 || first_c1 !== d1) begin errors++; $display("FAIL shared_data got=%h/%h exp=%h/%h", first_c0, first_c1, d0, d1); end
    deqRx = 1; cycle(); deqRx = 0;
    checks++; if (notEmpty !== 1'b0 || first_c0_valid !== 1'b0 || first_c1_valid !== 1'b0) begin errors++; $display("FAIL shared_deq got=%b%b%b exp=000", notEmpty, first_c0_valid, first_c1_valid); end
  endtask

  task automatic fill8();
    do_reset();
    for (int i = 0; i < N; i++) begin
      rx_c0_valid = 1; rx_c0_data = W0'(100 + i); cycle();
    end
    idle();
  endtask

  task automatic drain_count(output int cnt);
    cnt = 0;
    while (notEmpty === 1'b1 && cnt < 20) begin
      deqRx = 1; cycle(); cnt++;
    end
    deqRx = 0;
  endtask

  task automatic test_overflow();
    int cnt;
    fill8();
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_before got=%b exp=0", err_overflow); end
    rx_c0_valid = 1; rx_c0_data = W0'(999); cycle(); idle();
    checks++; if (err_overflow !== 1'b1 || err_overflow !== m_ovf) begin errors++; $display("FAIL ovf_set got=%b exp=1", err_overflow); end
    checks++; if (first_c0 !== W0'(100)) begin errors++; $display("FAIL ovf_head got=%0d exp=100", first_c0); end
    drain_count(cnt);
    checks++; if (cnt != N) begin errors++; $display("FAIL ovf_occ got=%0d exp=%0d", cnt, N); end
    fill8();
    rx_c0_valid = 1; rx_c0_data = W0'(999); deqRx = 1; cycle(); idle();
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_deq_err got=%b exp=0", err_overflow); end
    checks++; if (first_c0 !== W0'(101)) begin errors++; $display("FAIL ovf_deq_head got=%0d exp=101", first_c0); end
    drain_count(cnt);
    checks++; if (cnt != N) begin errors++; $display("FAIL ovf_deq_occ got=%0d exp=%0d", cnt, N); end
  endtask

  task automatic test_orphan();
    do_reset();
    rx_c1_valid = 1; rx_c1_data = 16'hbeef; cycle(); idle();
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_flag got=%b exp=1", err_orphan); end
    checks++; if (notEmpty !== 1'b1 || first_c1_valid !== 1'b1 || first_c0_valid !== 1'b0 || first_c1 !== 16'hbeef) begin errors++; $display("FAIL orphan_enq got=%b%b%b/%h exp=110/beef", notEmpty, first_c1_valid, first_c0_valid, first_c1); end
    // free = 8 - occ(1) - out_c1; stays clear only if out_c1 held at 0.
    checks++; if (txAlmFull !== 1'b0) begin errors++; $display("FAIL orphan_sat got=%b exp=0", txAlmFull); end
    for (int i = 0; i < 3; i++) begin
      req_c1_issue = 1; cycle();
      checks++; if (txAlmFull !== (i == 2) || txAlmFull !== exp_alm()) begin errors++; $display("FAIL orphan_issue[%0d] got=%b exp=%b", i, txAlmFull, (i == 2)); end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    do_reset();
    for (int i = 0; i < N; i++) begin
      rx_c0_valid = 1; rx_c0_data = W0'(i); cycle();
    end
    for (int i = N; i < 2 * N; i++) begin
      checks++; if (first_c0 !== W0'(idx)) begin errors++; $display("FAIL wrap_order[%0d] got=%0d exp=%0d", idx, first_c0, idx); end
      rx_c0_valid = 1; rx_c0_data = W0'(i); deqRx = 1; cycle(); idx++;
    end
    idle();
    while (idx < 2 * N) begin
      checks++; if (notEmpty !== 1'b1 || first_c0 !== W0'(idx)) begin errors++; $display("FAIL wrap_order[%0d] got=%b/%0d exp=1/%0d", idx, notEmpty, first_c0, idx); end
      deqRx = 1; cycle(); idx++;
    end
    idle();
    checks++; if (notEmpty !== 1'b0 || err_overflow !== 1'b0) begin errors++; $display("FAIL wrap_end got=%b%b exp=00", notEmpty, err_overflow); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rx_c0_valid  = ($urandom_range(3) == 0);
      rx_c1_valid  = ($urandom_range(3) == 0);
      rx_c0_data   = {$urandom, $urandom};
      rx_c1_data   = W1'($urandom);
      req_c0_issue = !exp_alm() && ($urandom_range(2) == 0);
      req_c1_issue = !exp_alm() && ($urandom_range(2) == 0);
      deqRx        = ($urandom_range(2) != 0);
      cycle();
      checks++; if (notEmpty !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_notEmpty c=%0d got=%b exp=%b", c, notEmpty, mq.size() > 0); end
      checks++; if (txAlmFull !== exp_alm()) begin errors++; $display("FAIL rnd_alm c=%0d got=%b exp=%b", c, txAlmFull, exp_alm()); end
      checks++; if (err_overflow !== m_ovf || err_orphan !== m_orph) begin errors++; $display("FAIL rnd_err c=%0d got=%b%b exp=%b%b", c, err_overflow, err_orphan, m_ovf, m_orph); end
      if (mq.size() > 0) begin
        checks++; if (first_c0_valid !== mq[0].v0 || first_c1_valid !== mq[0].v1) begin errors++; $display("FAIL rnd_hvalid c=%0d got=%b%b exp=%b%b", c, first_c0_valid, first_c1_valid, mq[0].v0, mq[0].v1); end
        checks++; if ((mq[0].v0 && first_c0 !== mq[0].d0) || (mq[0].v1 && first_c1 !== mq[0].d1)) begin errors++; $display("FAIL rnd_hdata c=%0d got=%h/%h exp=%h/%h", c, first_c0, first_c1, mq[0].d0, mq[0].d1); end
      end else begin
        checks++; if (first_c0_valid !== 1'b0 || first_c1_valid !== 1'b0) begin errors++; $display("FAIL rnd_empty_valid c=%0d got=%b%b exp=00", c, first_c0_valid, first_c1_valid); end
      end
    end
    // Reset mid-traffic must discard entries, counts and flags.
    reset = 1; cycle(); reset = 0; idle(); cycle();
    checks++; if (notEmpty !== 1'b0 || txAlmFull !== 1'b0 || err_overflow !== 1'b0 || err_orphan !== 1'b0) begin errors++; $display("FAIL rnd_reset got=%b%b%b%b exp=0000", notEmpty, txAlmFull, err_overflow, err_orphan); end
  endtask

  initial begin
    idle(); reset = 1;
    test_reset();
    test_credit_throttle();
    test_shared_entry();
    test_overflow();
    test_orphan();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
